datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port data_bus, input, 16 bits: instruction word from memory.
REQ-004 The block SHALL have port out, input, 16 bits: memory read data, used as the ALU B operand.
REQ-005 The block SHALL have load-enable inputs ldIR, ldMAR, ldSP, ldPC, ldReg and ldALUreg, each 1 bit, active-high.
REQ-006 The block SHALL have internal-bus drive-enable inputs Tlabel, Tsp, Tpc, Treg and ALUon, each 1 bit, active-high.
REQ-007 The block SHALL have port fnSelect, input, 3 bits: ALU operation.
REQ-008 The block SHALL have port mm, input, 1 bit: ALU B-operand select (1 = out, 0 = register).
REQ-009 The block SHALL have port ir_1, output, 4 bits: IR[15:12] (opcode).
REQ-010 The block SHALL have port ir_2, output, 2 bits: IR[11:10] (register field A).
REQ-011 The block SHALL have port funct, output, 3 bits: IR[2:0].
REQ-012 The block SHALL have port addr_bus, output, 16 bits: MAR contents.

Function
REQ-013 State SHALL comprise 16-bit registers IR, MAR, PC, SP and ALUreg, plus a register file R0..R3 of 16 bits each.
REQ-014 The internal bus ibus SHALL be a priority mux, highest first: Tlabel selects sign-extended IR[9:0]; Tsp selects SP; Tpc selects PC; Treg selects R[IR[9:8]]; ALUon selects ALUreg; with no enable asserted, ibus is 16'h0000.
REQ-015 On a clock edge, ldIR SHALL load IR <= data_bus.
REQ-016 On a clock edge, ldMAR SHALL load MAR <= ibus, ldPC SHALL load PC <= ibus, and ldSP SHALL load SP <= ibus.
REQ-017 On a clock edge, ldReg SHALL load R[IR[11:10]] <= ibus, using the IR value held before that edge.
REQ-018 All loads in one cycle SHALL use pre-edge values, so loading IR together with ldReg uses the old IR fields.
REQ-019 ALU operand A SHALL be R[IR[11:10]], and operand B SHALL be out when mm=1, else R[IR[9:8]].
REQ-020 fnSelect SHALL decode as: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 ~A, 110 A<<1, 111 A>>1 (logical); results are 16-bit and wrap modulo 2^16.
REQ-021 The ALU SHALL be combinational, and ldALUreg SHALL load ALUreg <= ALU result on the clock edge.
REQ-022 ir_1, ir_2 and funct SHALL be combinational slices of IR; addr_bus SHALL equal MAR.
REQ-023 Simultaneous drive enables SHALL resolve by the REQ-014 priority only; there SHALL be no multiple-driver hazards.

Reset
REQ-024 rst_n=0 SHALL immediately clear IR, MAR, PC, ALUreg and R0..R3 to 16'h0000 and set SP to 16'hFFFF.
REQ-025 While rst_n=0, outputs SHALL read ir_1=0, ir_2=0, funct=0 and addr_bus=0.
REQ-026 Reset asserted mid-operation SHALL override all pending loads.

Structure
REQ-027 The ALU opcode constants (ADD, SUB, AND, OR, XOR, NOT, SHL, SHR) and the reset value of SP SHALL live in a shared package datapath_pkg.
REQ-028 The ALU SHALL be one sub-module, datapath_alu; the register file, IR, MAR, PC, SP, ALUreg and the bus mux SHALL be inline.

Verification
REQ-029 Bench SHALL check: pulse rst_n low -> addr_bus=0000, ir_1=0, ir_2=0, funct=0.
REQ-030 Bench SHALL check: data_bus=F155 with ldIR -> next edge ir_1=F, ir_2=0, funct=5; then data_bus=F775 with ldIR -> ir_1=F, ir_2=1, funct=5.
REQ-031 Bench SHALL check: IR=0200 with Tlabel and ldMAR -> addr_bus=FE00 (sign extension of IR[9:0]).
REQ-032 Bench SHALL check: IR=0005 with Tlabel and ldReg (R0=5); then out=0003, mm=1, fnSelect=000, ldALUreg; then ALUon and ldMAR -> addr_bus=0008.
REQ-033 Bench SHALL check: after reset, Tpc=1, ALUon=1 and ldSP -> SP=0000 (PC wins over ALUreg); then Tsp and ldMAR -> addr_bus=0000.
REQ-034 Bench SHALL check: load MAR=1234, then assert rst_n=0 between clock edges -> addr_bus=0000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath block.
//   alu_op_e  : ALU operation encoding carried on fnSelect
//   SP_RESET  : value the stack pointer takes on reset (top of memory)
//   sign_ext10: widens a 10-bit IR label field to a full word
package datapath_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100,
        NOT = 3'b101,
        SHL = 3'b110,
        SHR = 3'b111
    } alu_op_e;

    localparam logic [WORD_W-1:0] SP_RESET = 16'hFFFF;

    function automatic logic [WORD_W-1:0] sign_ext10(input logic [9:0] v);
        return {{(WORD_W-10){v[9]}}, v};
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU for the datapath.
//   a      : operand A (register selected by IR[11:10])
//   b      : operand B (memory data or register selected by IR[9:8])
//   fn     : operation select
//   result : 16-bit result, wrapping modulo 2^16
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  alu_op_e           fn,
    output logic [WORD_W-1:0] result
);

    always_comb begin
        result = '0;
        case (fn)
            ADD:     result = a + b;
            SUB:     result = a - b;
            AND:     result = a & b;
            OR:      result = a | b;
            XOR:     result = a ^ b;
            NOT:     result = ~a;
            SHL:     result = {a[WORD_W-2:0], 1'b0};
            SHR:     result = {1'b0, a[WORD_W-1:1]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Processor datapath: IR, MAR, PC, SP, ALU result register, a 4-entry
// register file and a priority-muxed internal bus feeding all of them.
//   clk, rst_n          : clock, asynchronous active-low reset
//   data_bus            : instruction word loaded into IR
//   out                 : memory read data, ALU B operand when mm=1
//   ldIR..ldALUreg      : register load enables
//   Tlabel..ALUon       : internal bus source enables (priority order)
//   fnSelect, mm        : ALU operation and B-operand select
//   ir_1, ir_2, funct   : opcode, register field A and function slices of IR
//   addr_bus            : MAR contents
module datapath
    import datapath_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WORD_W-1:0]   data_bus,
    input  logic [WORD_W-1:0]   out,
    input  logic                ldIR,
    input  logic                ldMAR,
    input  logic                ldSP,
    input  logic                ldPC,
    input  logic                ldReg,
    input  logic                ldALUreg,
    input  logic                Tlabel,
    input  logic                Tsp,
    input  logic                Tpc,
    input  logic                Treg,
    input  logic                ALUon,
    input  logic [2:0]          fnSelect,
    input  logic                mm,
    output logic [3:0]          ir_1,
    output logic [1:0]          ir_2,
    output logic [2:0]          funct,
    output logic [WORD_W-1:0]   addr_bus
);

    logic [WORD_W-1:0] ir_reg;
    logic [WORD_W-1:0] mar_reg;
    logic [WORD_W-1:0] pc_reg;
    logic [WORD_W-1:0] sp_reg;
    logic [WORD_W-1:0] alu_reg;
    logic [3:0][WORD_W-1:0] rf;
    logic [WORD_W-1:0] ibus;
    logic [WORD_W-1:0] alu_b;
    logic [WORD_W-1:0] alu_result;

    // Single mux with a fixed priority, so overlapping enables can never
    // produce contention on the bus.
    always_comb begin
        ibus = '0;
        if (Tlabel)
            ibus = sign_ext10(ir_reg[9:0]);
        else if (Tsp)
            ibus = sp_reg;
        else if (Tpc)
            ibus = pc_reg;
        else if (Treg)
            ibus = rf[ir_reg[9:8]];
        else if (ALUon)
            ibus = alu_reg;
    end

    assign alu_b = mm ? out : rf[ir_reg[9:8]];

    datapath_alu u_alu (
        .a      (rf[ir_reg[11:10]]),
        .b      (alu_b),
        .fn     (alu_op_e'(fnSelect)),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg  <= '0;
            mar_reg <= '0;
            pc_reg  <= '0;
            sp_reg  <= SP_RESET;
            alu_reg <= '0;
        end else begin
            if (ldIR)     ir_reg  <= data_bus;
            if (ldMAR)    mar_reg <= ibus;
            if (ldPC)     pc_reg  <= ibus;
            if (ldSP)     sp_reg  <= ibus;
            if (ldALUreg) alu_reg <= alu_result;
        end
    end

    // The write select is decoded from the IR value present before the
    // edge, so an IR load in the same cycle does not redirect the write.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rf
        logic [WORD_W-1:0] r_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_reg <= '0;
            else if (ldReg && (ir_reg[11:10] == 2'(gi)))
                r_reg <= ibus;
        end

        assign rf[gi] = r_reg;
    end

    assign ir_1     = ir_reg[15:12];
    assign ir_2     = ir_reg[11:10];
    assign funct    = ir_reg[2:0];
    assign addr_bus = mar_reg;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_bus;
    logic [15:0] out_data;
    logic        ldIR, ldMAR, ldSP, ldPC, ldReg, ldALUreg;
    logic        Tlabel, Tsp, Tpc, Treg, ALUon;
    logic [2:0]  fnSelect;
    logic        mm;
    logic [3:0]  ir_1;
    logic [1:0]  ir_2;
    logic [2:0]  funct;
    logic [15:0] addr_bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datapath dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_bus (data_bus),
        .out      (out_data),
        .ldIR     (ldIR),
        .ldMAR    (ldMAR),
        .ldSP     (ldSP),
        .ldPC     (ldPC),
        .ldReg    (ldReg),
        .ldALUreg (ldALUreg),
        .Tlabel   (Tlabel),
        .Tsp      (Tsp),
        .Tpc      (Tpc),
        .Treg     (Treg),
        .ALUon    (ALUon),
        .fnSelect (fnSelect),
        .mm       (mm),
        .ir_1     (ir_1),
        .ir_2     (ir_2),
        .funct    (funct),
        .addr_bus (addr_bus)
    );

    // Control word bit positions: {ldIR,ldMAR,ldSP,ldPC,ldReg,ldALUreg,Tlabel,Tsp,Tpc,Treg,ALUon}
    localparam logic [10:0] C_LDIR   = 11'h400;
    localparam logic [10:0] C_LDMAR  = 11'h200;
    localparam logic [10:0] C_LDSP   = 11'h100;
    localparam logic [10:0] C_LDPC   = 11'h080;
    localparam logic [10:0] C_LDREG  = 11'h040;
    localparam logic [10:0] C_LDALU  = 11'h020;
    localparam logic [10:0] C_TLABEL = 11'h010;
    localparam logic [10:0] C_TSP    = 11'h008;
    localparam logic [10:0] C_TPC    = 11'h004;
    localparam logic [10:0] C_TREG   = 11'h002;
    localparam logic [10:0] C_ALUON  = 11'h001;

    typedef struct {
        string       name;
        logic [10:0] c;
        logic [15:0] db;
        logic [15:0] ov;
        logic [2:0]  f;
        logic        m;
        logic [3:0]  e_ir1;
        logic [1:0]  e_ir2;
        logic [2:0]  e_fn;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vecs [16];

    // Reference model state
    logic [15:0] m_ir, m_mar, m_pc, m_sp, m_alu;
    logic [15:0] m_r [4];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] e1, input logic [1:0] e2,
                              input logic [2:0] ef, input logic [15:0] ea);
        check({tag, ".ir_1"},     16'(ir_1),  16'(e1));
        check({tag, ".ir_2"},     16'(ir_2),  16'(e2));
        check({tag, ".funct"},    16'(funct), 16'(ef));
        check({tag, ".addr_bus"}, addr_bus,   ea);
        $display("txn %-16s ir_1=%h ir_2=%h funct=%h addr_bus=%h", tag, ir_1, ir_2, funct, addr_bus);
    endtask

    task automatic set_inputs(input logic [10:0] c, input logic [15:0] db, input logic [15:0] ov,
                              input logic [2:0] f, input logic m);
        {ldIR, ldMAR, ldSP, ldPC, ldReg, ldALUreg, Tlabel, Tsp, Tpc, Treg, ALUon} = c;
        data_bus = db;
        out_data = ov;
        fnSelect = f;
        mm       = m;
    endtask

    task automatic apply(input logic [10:0] c, input logic [15:0] db, input logic [15:0] ov,
                         input logic [2:0] f, input logic m);
        set_inputs(c, db, ov, f, m);
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a clock edge; releases reset mid-cycle.
    task automatic reset_pulse();
        set_inputs('0, '0, '0, 3'd0, 1'b0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input string n, input logic [10:0] c, input logic [15:0] db,
                                input logic [15:0] ov, input logic [2:0] f, input logic m,
                                input logic [3:0] e1, input logic [1:0] e2, input logic [2:0] ef,
                                input logic [15:0] ea);
        vec_t v;
        v.name = n; v.c = c; v.db = db; v.ov = ov; v.f = f; v.m = m;
        v.e_ir1 = e1; v.e_ir2 = e2; v.e_fn = ef; v.e_addr = ea;
        return v;
    endfunction

    // Reference model, written from the architectural rules.
    function automatic logic [15:0] model_bus(input logic [10:0] c);
        int lbl;
        if ((c & C_TLABEL) != 0) begin
            lbl = int'(m_ir[9:0]);
            if (lbl >= 512) lbl -= 1024;
            return 16'(lbl);
        end
        if ((c & C_TSP) != 0)   return m_sp;
        if ((c & C_TPC) != 0)   return m_pc;
        if ((c & C_TREG) != 0)  return m_r[m_ir[9:8]];
        if ((c & C_ALUON) != 0) return m_alu;
        return 16'h0000;
    endfunction

    function automatic logic [15:0] model_alu(input logic [2:0] f, input logic m, input logic [15:0] ov);
        int a, b;
        a = int'(m_r[m_ir[11:10]]);
        b = m ? int'(ov) : int'(m_r[m_ir[9:8]]);
        case (f)
            3'd0: return 16'((a + b) % 65536);
            3'd1: return 16'((a - b + 65536) % 65536);
            3'd2: return 16'(a) & 16'(b);
            3'd3: return 16'(a) | 16'(b);
            3'd4: return 16'(a) ^ 16'(b);
            3'd5: return 16'(65535 - a);
            3'd6: return 16'((a * 2) % 65536);
            default: return 16'(a / 2);
        endcase
    endfunction

    task automatic model_reset();
        m_ir = '0; m_mar = '0; m_pc = '0; m_alu = '0; m_sp = 16'hFFFF;
        for (int k = 0; k < 4; k++) m_r[k] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] c;
        logic [15:0] db, ov, bus, alu;
        logic [2:0]  f;
        logic        m;
        logic [1:0]  wsel;

        vecs[0]  = mk("ldir_f155",     C_LDIR, 16'hF155, 16'h0, 3'd0, 1'b0, 4'hF, 2'd0, 3'd5, 16'h0000);
        vecs[1]  = mk("ldir_f775",     C_LDIR, 16'hF775, 16'h0, 3'd0, 1'b0, 4'hF, 2'd1, 3'd5, 16'h0000);
        vecs[2]  = mk("ldir_0200",     C_LDIR, 16'h0200, 16'h0, 3'd0, 1'b0, 4'h0, 2'd0, 3'd0, 16'h0000);
        vecs[3]  = mk("label_sext",    C_TLABEL | C_LDMAR, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0, 2'd0, 3'd0, 16'hFE00);
        vecs[4]  = mk("ldir_0005",     C_LDIR, 16'h0005, 16'h0, 3'd0, 1'b0, 4'h0, 2'd0, 3'd5, 16'hFE00);
        vecs[5]  = mk("label_to_r0",   C_TLABEL | C_LDREG, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0, 2'd0, 3'd5, 16'hFE00);
        vecs[6]  = mk("alu_add_mem",   C_LDALU, 16'h0, 16'h0003, 3'd0, 1'b1, 4'h0, 2'd0, 3'd5, 16'hFE00);
        vecs[7]  = mk("alu_to_mar",    C_ALUON | C_LDMAR, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0, 2'd0, 3'd5, 16'h0008);
        vecs[8]  = mk("pc_over_alu",   C_TPC | C_ALUON | C_LDSP, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0, 2'd0, 3'd5, 16'h0008);
        vecs[9]  = mk("sp_to_mar",     C_TSP | C_LDMAR, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0, 2'd0, 3'd5, 16'h0000);
        vecs[10] = mk("ir_with_ldreg", C_LDIR | C_LDREG | C_ALUON, 16'h0C01, 16'h0, 3'd0, 1'b0, 4'h0, 2'd3, 3'd1, 16'h0000);
        vecs[11] = mk("treg_to_mar",   C_TREG | C_LDMAR, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0, 2'd3, 3'd1, 16'h0008);
        vecs[12] = mk("alu_sub_wrap",  C_LDALU, 16'h0, 16'h0, 3'd1, 1'b0, 4'h0, 2'd3, 3'd1, 16'h0008);
        vecs[13] = mk("alu_to_mar2",   C_ALUON | C_LDMAR, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0, 2'd3, 3'd1, 16'hFFF8);
        vecs[14] = mk("label_over_all", C_TLABEL | C_TSP | C_TPC | C_TREG | C_ALUON | C_LDMAR,
                      16'h0, 16'h0, 3'd0, 1'b0, 4'h0, 2'd3, 3'd1, 16'h0001);
        vecs[15] = mk("treg_over_alu", C_TREG | C_ALUON | C_LDMAR, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0, 2'd3, 3'd1, 16'h0008);

        // Power-on reset, observed while held and after release.
        set_inputs('0, '0, '0, 3'd0, 1'b0);
        rst_n = 1'b0;
        #7;
        check_outs("reset_held", 4'h0, 2'd0, 3'd0, 16'h0000);
        #5;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].c, vecs[i].db, vecs[i].ov, vecs[i].f, vecs[i].m);
            check_outs(vecs[i].name, vecs[i].e_ir1, vecs[i].e_ir2, vecs[i].e_fn, vecs[i].e_addr);
        end

        // Stack pointer reset value and PC-over-ALU priority straight from reset.
        reset_pulse();
        check_outs("reset_pulse", 4'h0, 2'd0, 3'd0, 16'h0000);
        apply(C_TSP | C_LDMAR, '0, '0, 3'd0, 1'b0);
        check_outs("sp_reset_val", 4'h0, 2'd0, 3'd0, 16'hFFFF);
        apply(C_TPC | C_ALUON | C_LDSP, '0, '0, 3'd0, 1'b0);
        apply(C_TSP | C_LDMAR, '0, '0, 3'd0, 1'b0);
        check_outs("sp_from_pc", 4'h0, 2'd0, 3'd0, 16'h0000);

        // MAR=1234 via the ALU, then reset between edges with a load pending.
        apply(C_LDALU, '0, 16'h1234, 3'd0, 1'b1);
        apply(C_ALUON | C_LDMAR, '0, '0, 3'd0, 1'b0);
        check_outs("mar_1234", 4'h0, 2'd0, 3'd0, 16'h1234);
        #3;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 4'h0, 2'd0, 3'd0, 16'h0000);
        set_inputs(C_ALUON | C_LDMAR | C_LDIR, 16'hABCD, '0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        check_outs("reset_overrides", 4'h0, 2'd0, 3'd0, 16'h0000);
        rst_n = 1'b1;
        set_inputs('0, '0, '0, 3'd0, 1'b0);
        model_reset();

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 11; k++) c[k] = ($urandom_range(0, 2) == 0);
            db = 16'($urandom);
            ov = 16'($urandom);
            f  = 3'($urandom_range(0, 7));
            m  = 1'($urandom_range(0, 1));
            bus  = model_bus(c);
            alu  = model_alu(f, m, ov);
            wsel = m_ir[11:10];
            if ((c & C_LDIR)  != 0) m_ir  = db;
            if ((c & C_LDMAR) != 0) m_mar = bus;
            if ((c & C_LDPC)  != 0) m_pc  = bus;
            if ((c & C_LDSP)  != 0) m_sp  = bus;
            if ((c & C_LDALU) != 0) m_alu = alu;
            if ((c & C_LDREG) != 0) m_r[wsel] = bus;
            apply(c, db, ov, f, m);
            check_outs($sformatf("rand_%0d", i), m_ir[15:12], m_ir[11:10], m_ir[2:0], m_mar);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
